prince_host_if: RTL and testbench

Host-side load/unload front end for the masked PRINCE core and its round controller. It loads the plaintext (or ciphertext) shares over a 32-bit valid/ready stream and derives the whitening keys k0/k0'. It then pulses the controller reset, holds its enable until the controller reports done, and streams the result shares back out. It sits between the system bus adapter and the core/controller pair and owns the only handshake the core exposes to the outside.

---
 rtl/prince_pkg.sv | 20 ++
 rtl/prince_share_buf.sv | 37 +++
 rtl/prince_host_if.sv | 167 ++++++++++++++++
 tb/tb_prince_host_if.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/prince_pkg.sv
// Shared definitions for the PRINCE host interface: share count, FSM encoding,
// the k0' whitening-key derivation and the PRINCE alpha constant.
package prince_pkg;

    localparam int NSHARES_DEF = 5;
    localparam logic [63:0] ALPHA = 64'hc0ac29b7c97c50dd;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CRST,
        ST_RUN,
        ST_UNLOAD
    } state_t;

    function automatic logic [63:0] k0_prime(input logic [63:0] k0);
        return {k0[0], k0[63:1]} ^ {63'b0, k0[63]};
    endfunction

endpackage

// File: rtl/prince_share_buf.sv
// WORDS x 32-bit share register file: word-indexed writes, whole-buffer parallel
// load, and a flat view with share i at bits [64i+63:64i] (even word = high half).
module prince_share_buf
    import prince_pkg::*;
#(
    parameter int NSHARES = NSHARES_DEF,
    localparam int WORDS = 2 * NSHARES,
    localparam int IW = $clog2(WORDS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [IW-1:0]          wr_idx,
    input  logic [31:0]            wr_data,
    input  logic                   ld_en,
    input  logic [64*NSHARES-1:0]  ld_data,
    output logic [64*NSHARES-1:0]  flat
);

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
        localparam int OFS = 64 * (gi / 2) + 32 * (1 - (gi % 2));
        logic [31:0] word_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                word_reg <= '0;
            end else if (ld_en) begin
                word_reg <= ld_data[OFS +: 32];
            end else if (wr_en && (wr_idx == IW'(gi))) begin
                word_reg <= wr_data;
            end
        end

        assign flat[OFS +: 32] = word_reg;
    end

endmodule

// File: rtl/prince_host_if.sv
// Host load/unload front end for the masked PRINCE core: loads shares over a
// 32-bit stream, sequences the round controller, and streams result shares out.
module prince_host_if
    import prince_pkg::*;
#(
    parameter int NSHARES = NSHARES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enc,
    input  logic [127:0]           key,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   core_rst,
    output logic                   core_en,
    output logic                   core_enc,
    input  logic                   core_done,
    output logic [64*NSHARES-1:0]  core_din,
    input  logic [64*NSHARES-1:0]  core_dout,
    output logic [63:0]            core_kin,
    output logic [63:0]            core_kout,
    output logic [63:0]            core_k1
);

    localparam int WORDS = 2 * NSHARES;
    localparam int CW = $clog2(WORDS + 1);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    state_t           state_reg, state_next;
    logic [CW-1:0]    wcnt_reg, wcnt_next;
    logic             enc_reg;
    logic [127:0]     key_reg;
    logic             in_wr, out_ld, cfg_ld;
    logic [64*NSHARES-1:0] in_flat, out_flat;
    logic [63:0]      k0, k0p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            wcnt_reg  <= '0;
            enc_reg   <= 1'b1;
            key_reg   <= '0;
        end else begin
            state_reg <= state_next;
            wcnt_reg  <= wcnt_next;
            if (cfg_ld) begin
                enc_reg <= enc;
                key_reg <= key;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        core_rst   = 1'b0;
        core_en    = 1'b0;
        in_wr      = 1'b0;
        out_ld     = 1'b0;
        cfg_ld     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                core_rst = 1'b1;
                if (in_valid) begin
                    in_wr  = 1'b1;
                    cfg_ld = 1'b1;
                    if (WORDS == 1) begin
                        wcnt_next  = '0;
                        state_next = ST_CRST;
                    end else begin
                        wcnt_next  = CW'(1);
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                core_rst = 1'b1;
                if (in_valid) begin
                    in_wr = 1'b1;
                    if (wcnt_reg == LAST) begin
                        wcnt_next  = '0;
                        state_next = ST_CRST;
                    end else begin
                        wcnt_next = wcnt_reg + CW'(1);
                    end
                end
            end
            ST_CRST: begin
                core_rst   = 1'b1;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                core_en = 1'b1;
                if (core_done) begin
                    out_ld     = 1'b1;
                    wcnt_next  = '0;
                    state_next = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (wcnt_reg == LAST) begin
                        wcnt_next  = '0;
                        state_next = ST_IDLE;
                    end else begin
                        wcnt_next = wcnt_reg + CW'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    prince_share_buf #(.NSHARES(NSHARES)) u_in_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_wr),
        .wr_idx  (wcnt_reg),
        .wr_data (in_data),
        .ld_en   (1'b0),
        .ld_data ('0),
        .flat    (in_flat)
    );

    prince_share_buf #(.NSHARES(NSHARES)) u_out_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (1'b0),
        .wr_idx  ('0),
        .wr_data ('0),
        .ld_en   (out_ld),
        .ld_data (core_dout),
        .flat    (out_flat)
    );

    // Output word select uses the same word ordering as the load path.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (wcnt_reg == CW'(i)) begin
                out_data = out_flat[64 * (i / 2) + 32 * (1 - (i % 2)) +: 32];
            end
        end
    end

    assign out_last  = (state_reg == ST_UNLOAD) && (wcnt_reg == LAST);
    assign busy      = (state_reg != ST_IDLE);
    assign core_enc  = enc_reg;
    assign core_din  = in_flat;
    assign k0        = key_reg[127:64];
    assign k0p       = k0_prime(k0);
    assign core_kin  = enc_reg ? k0 : k0p;
    assign core_kout = enc_reg ? k0p : k0;
    assign core_k1   = key_reg[63:0];

endmodule

// File: tb/tb_prince_host_if.sv
// Randomized bench for prince_host_if with a stub core whose result is a simple
// function of the shares and keys, checked against a word-level reference model.
module tb_prince_host_if;
    import prince_pkg::*;

    localparam int NS = 5;
    localparam int NW = 2 * NS;

    logic              clk = 1'b0;
    logic              rst;
    logic              enc;
    logic [127:0]      key;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic              out_last;
    logic              busy;
    logic              core_rst;
    logic              core_en;
    logic              core_enc;
    logic              core_done;
    logic [64*NS-1:0]  core_din;
    logic [64*NS-1:0]  core_dout;
    logic [63:0]       core_kin;
    logic [63:0]       core_kout;
    logic [63:0]       core_k1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    prince_host_if #(.NSHARES(NS)) dut (
        .clk       (clk),
        .rst       (rst),
        .enc       (enc),
        .key       (key),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .core_rst  (core_rst),
        .core_en   (core_en),
        .core_enc  (core_enc),
        .core_done (core_done),
        .core_din  (core_din),
        .core_dout (core_dout),
        .core_kin  (core_kin),
        .core_kout (core_kout),
        .core_k1   (core_k1)
    );

    // Stub core: done after n_run enabled cycles; result swaps each share's halves
    // and folds the keys and mode into share 0.
    int run_cnt = 0;
    int n_run = 13;
    always @(posedge clk) begin
        if (core_rst) run_cnt <= 0;
        else if (core_en) run_cnt <= run_cnt + 1;
    end
    assign core_done = core_en && (run_cnt == n_run - 1);

    always_comb begin
        core_dout = '0;
        for (int i = 0; i < NS; i++)
            core_dout[64*i +: 64] = {core_din[64*i +: 32], core_din[64*i+32 +: 32]};
        core_dout[63:0] = core_dout[63:0] ^ core_kin ^ core_kout ^ core_k1 ^ {63'b0, core_enc};
    end

    int acc_cnt = 0;
    always @(posedge clk) if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [31:0] w [NW];
    logic [31:0] e [NW];
    logic [63:0] obs_kin, obs_kout;

    // Reference: result word 2i is the low half of input share i and vice versa;
    // share 0 additionally carries kin ^ kout ^ k1 ^ enc.
    task automatic model(input bit enc_i, input logic [127:0] key_i,
                         output logic [63:0] kin, output logic [63:0] kout);
        logic [63:0] k0, k1, k0p, mask;
        k0   = key_i[127:64];
        k1   = key_i[63:0];
        k0p  = ((k0 >> 1) | (k0 << 63)) ^ (k0 >> 63);
        kin  = enc_i ? k0 : k0p;
        kout = enc_i ? k0p : k0;
        mask = kin ^ kout ^ k1 ^ {63'b0, enc_i};
        for (int i = 0; i < NS; i++) begin
            e[2*i]   = w[2*i+1];
            e[2*i+1] = w[2*i];
        end
        e[0] = e[0] ^ mask[63:32];
        e[1] = e[1] ^ mask[31:0];
    endtask

    task automatic run_op(input bit enc_i, input logic [127:0] key_i, input int nrun,
                          input int gap, input int stall0, input int abort_at);
        logic [63:0] kin_m, kout_m;
        int acc0, cyc, guard, stall;
        bit aborted;
        aborted = 1'b0;
        n_run = nrun;
        for (int j = 0; j < NW; j++) w[j] = $urandom;
        model(enc_i, key_i, kin_m, kout_m);
        acc0 = acc_cnt;
        enc = enc_i;
        key = key_i;
        for (int j = 0; j < NW; j++) begin
            in_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_data  = w[j];
            guard = 0;
            do begin @(negedge clk); guard++; end while (!in_ready && guard < 50);
            chk("accept", in_ready, 1'b1);
            @(posedge clk); #1;
            if (j == 0) begin
                key = {$urandom, $urandom, $urandom, $urandom};
                enc = ~enc_i;
            end
        end
        in_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk("accepts", acc_cnt - acc0, NW);
                chk("crst_rst", core_rst, 1'b1);
                chk("crst_en", core_en, 1'b0);
                chk("crst_rdy", in_ready, 1'b0);
            end
            if (cyc == 2) begin
                chk("run_en", core_en, 1'b1);
                chk("run_rst", core_rst, 1'b0);
                chk("run_enc", core_enc, enc_i);
                chk("run_kin", core_kin, kin_m);
                chk("run_kout", core_kout, kout_m);
                chk("run_k1", core_k1, key_i[63:0]);
                obs_kin  = core_kin;
                obs_kout = core_kout;
            end
        end while (!out_valid && cyc < 200);
        chk("latency", cyc, nrun + 2);
        @(posedge clk); #1;
        for (int j = 0; j < NW && !aborted; j++) begin
            out_ready = 1'b0;
            if (j == abort_at) begin
                #2 rst = 1'b1;
                #1;
                chk("abort_valid", out_valid, 1'b0);
                chk("abort_busy", busy, 1'b0);
                @(negedge clk); rst = 1'b0;
                @(negedge clk);
                chk("abort_rdy", in_ready, 1'b1);
                chk("abort_noout", out_valid, 1'b0);
                @(posedge clk); #1;
                aborted = 1'b1;
            end else begin
                stall = (j == 0 && stall0 > 0) ? stall0 : int'($urandom_range(2, 0));
                repeat (stall) begin
                    @(negedge clk);
                    chk("hold_data", out_data, e[j]);
                    chk("hold_rdy", in_ready, 1'b0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
                @(negedge clk);
                chk("out_valid", out_valid, 1'b1);
                chk("out_data", out_data, e[j]);
                chk("out_last", out_last, (j == NW - 1));
                @(posedge clk); #1;
            end
        end
        out_ready = 1'b0;
        if (!aborted) begin
            @(negedge clk);
            chk("end_valid", out_valid, 1'b0);
            chk("end_busy", busy, 1'b0);
            @(posedge clk); #1;
        end
        $display("op enc=%0d key=%h nrun=%0d gap=%0d stall0=%0d abort=%0d", enc_i, key_i,
                 nrun, gap, stall0, abort_at);
    endtask

    initial begin
        rst = 1'b1; enc = 1'b0; key = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_core_rst", core_rst, 1'b1);
        chk("rst_core_en", core_en, 1'b0);
        chk("rst_core_enc", core_enc, 1'b1);
        chk("rst_core_kin", core_kin, 64'h0);
        chk("rst_core_din", core_din[63:0], 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(1'b1, 128'h0, 13, 0, 0, -1);
        run_op(1'b0, 128'h0, 13, 0, 0, -1);
        run_op(1'b1, {64'h8000000000000001, 64'h0123456789abcdef}, 13, 0, 0, -1);
        chk("kin_enc", obs_kin, 64'h8000000000000001);
        chk("kout_enc", obs_kout, 64'hC000000000000001);
        run_op(1'b0, {64'h8000000000000001, 64'h0123456789abcdef}, 13, 0, 0, -1);
        chk("kin_dec", obs_kin, 64'hC000000000000001);
        chk("kout_dec", obs_kout, 64'h8000000000000001);
        run_op(1'b1, {$urandom, $urandom, $urandom, $urandom}, 13, 0, 20, -1);
        run_op(1'b0, {$urandom, $urandom, $urandom, $urandom}, 13, 2, 0, -1);
        run_op(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1, 0, 0, -1);
        run_op(1'b1, {$urandom, $urandom, $urandom, $urandom}, 13, 0, 0, 4);
        run_op(1'b1, {$urandom, $urandom, $urandom, $urandom}, 13, 0, 0, -1);
        for (int k = 0; k < 4; k++)
            run_op(1'($urandom_range(1, 0)), {$urandom, $urandom, $urandom, $urandom},
                   int'($urandom_range(16, 1)), int'($urandom_range(2, 0)), 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
